// File: rtl/reflet_sleep_pkg.sv
// Shared constants and bus payload type for the Reflet sleep/wake controller.
package reflet_sleep_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_DELAY  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SLEEP = 2'd1;
    localparam logic [1:0] ST_WAKE  = 2'd2;

    typedef struct packed {
        logic              sel;
        logic              wr;
        logic [1:0]        offset;
        logic [DATA_W-1:0] data;
    } bus_req_t;

endpackage

// File: rtl/reflet_wake_timer.sv
// Loadable down-counter timing the stabilisation delay between wake event and CPU restart.
module reflet_wake_timer
    import reflet_sleep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             count,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] value_next;

    always_comb begin
        value_next = value;
        if (load) begin
            value_next = load_value;
        end else if (count && (value != '0)) begin
            value_next = value - CNT_W'(1);
        end
    end

    // expire is registered from the next value so it is high while value == 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value  <= '0;
            expire <= 1'b0;
        end else begin
            value  <= value_next;
            expire <= (value_next == CNT_W'(1));
        end
    end

endmodule

// File: rtl/reflet_sleep_ctrl.sv
// Memory-mapped sleep/wake controller: halts the CPU until a masked interrupt, then replays it.
module reflet_sleep_ctrl
    import reflet_sleep_pkg::*;
#(
    parameter int unsigned               base_addr_size = 15,
    parameter logic [base_addr_size-1:0] base_addr      = 15'h7F10,
    parameter int unsigned               irq_width      = 4,
    parameter logic [7:0]                delay_reset    = 8'h10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic [7:0]                data_in,
    input  logic                      write_en,
    output logic [7:0]                data_out,
    input  logic [irq_width-1:0]      irq_in,
    output logic [irq_width-1:0]      irq_out,
    output logic                      cpu_enable
);

    logic [base_addr_size-1:0] addr_off;
    bus_req_t                  req;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [irq_width-1:0] wake_mask;
    logic [CNT_W-1:0]     wake_delay;
    logic [irq_width-1:0] status;
    logic [irq_width-1:0] status_next;
    logic [irq_width-1:0] pending;
    logic [irq_width-1:0] pending_next;
    logic [irq_width-1:0] wake_hit;
    logic [irq_width-1:0] wake_set;
    logic [7:0]           rd_data;
    logic                 sleep_req;
    logic                 timer_load;
    logic                 timer_count;
    logic                 timer_expire;
    logic [CNT_W-1:0]     timer_value;

    // Address decode; unsigned wrap makes addresses below base fall out of range
    assign addr_off = addr - base_addr;

    always_comb begin
        req.sel    = enable && (addr_off < base_addr_size'(4));
        req.wr     = req.sel && write_en;
        req.offset = addr_off[1:0];
        req.data   = data_in;
    end

    assign sleep_req   = req.wr && (req.offset == REG_CTRL) && req.data[0];
    assign wake_hit    = irq_in & wake_mask;
    assign timer_count = (state == ST_WAKE);

    // Next-state logic; a sleep request with an empty mask is dropped to avoid deadlock
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        wake_set   = '0;
        case (state)
            ST_RUN: begin
                if (sleep_req && (wake_mask != '0)) begin
                    state_next = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (wake_hit != '0) begin
                    wake_set = wake_hit;
                    if (wake_delay == '0) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_WAKE;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_WAKE: begin
                if (timer_expire || (timer_value == '0)) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Wake-set bits win over a simultaneous write-1-to-clear
    always_comb begin
        status_next = status;
        if (req.wr && (req.offset == REG_STATUS)) begin
            status_next = status & ~req.data[irq_width-1:0];
        end
        status_next = status_next | wake_set;

        pending_next = cpu_enable ? '0 : pending;
        pending_next = pending_next | wake_set;
    end

    always_comb begin
        rd_data = '0;
        if (req.sel) begin
            case (req.offset)
                REG_CTRL:   rd_data = {7'b0, (state != ST_RUN)};
                REG_MASK:   rd_data = 8'(wake_mask);
                REG_DELAY:  rd_data = wake_delay;
                REG_STATUS: rd_data = 8'(status);
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RUN;
            cpu_enable <= 1'b1;
            wake_mask  <= '0;
            wake_delay <= delay_reset;
            status     <= '0;
            pending    <= '0;
            data_out   <= '0;
        end else begin
            state      <= state_next;
            cpu_enable <= (state_next == ST_RUN);
            status     <= status_next;
            pending    <= pending_next;
            data_out   <= rd_data;
            if (req.wr && (req.offset == REG_MASK)) begin
                wake_mask <= req.data[irq_width-1:0];
            end
            if (req.wr && (req.offset == REG_DELAY)) begin
                wake_delay <= req.data;
            end
        end
    end

    assign irq_out = irq_in | pending;

    reflet_wake_timer u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load       (timer_load),
        .load_value (wake_delay),
        .count      (timer_count),
        .value      (timer_value),
        .expire     (timer_expire)
    );

endmodule

// File: tb/tb_reflet_sleep_ctrl.sv
// Scoreboard bench for reflet_sleep_ctrl: stimulus queues expectations per cycle, a monitor checks them.
module tb_reflet_sleep_ctrl;

    localparam int unsigned     AW     = 15;
    localparam logic [AW-1:0]   BASE   = 15'h7F10;
    localparam int              K_DATA = 0;
    localparam int              K_CE   = 1;
    localparam int              K_IRQ  = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] addr;
    logic [7:0]    data_in;
    logic          write_en;
    logic [7:0]    data_out;
    logic [3:0]    irq_in;
    logic [3:0]    irq_out;
    logic          cpu_enable;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    reflet_sleep_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .addr       (addr),
        .data_in    (data_in),
        .write_en   (write_en),
        .data_out   (data_out),
        .irq_in     (irq_in),
        .irq_out    (irq_out),
        .cpu_enable (cpu_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle, mid-cycle
    always @(negedge clk) begin
        int         i;
        logic [7:0] act;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc <= cyc) begin
                case (q[i].kind)
                    K_DATA:  act = data_out;
                    K_CE:    act = {7'b0, cpu_enable};
                    default: act = {4'b0, irq_out};
                endcase
                n_checks++;
                if (q[i].cyc < cyc)
                    $display("FAIL %s: check due at cycle %0d missed (now %0d)", q[i].name, q[i].cyc, cyc);
                else if (act === q[i].val)
                    n_pass++;
                else
                    $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", q[i].name, act, q[i].val, cyc);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int k, input int kind, input logic [7:0] v, input string name);
        exp_t e;
        e.cyc  = cyc + k;
        e.kind = kind;
        e.val  = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        enable   = 1'b1;
        write_en = 1'b1;
        addr     = BASE + AW'(off);
        data_in  = d;
        tick(1);
        enable   = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] off, input logic [7:0] v, input string name);
        enable   = 1'b1;
        write_en = 1'b0;
        addr     = BASE + AW'(off);
        expect_at(1, K_DATA, v, name);
        tick(1);
        enable   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        write_en = 1'b0;
        addr     = '0;
        data_in  = 8'h00;
        irq_in   = 4'h0;

        // Reset values
        tick(2);
        expect_at(0, K_CE,   8'h01, "rst_cpu_enable");
        expect_at(0, K_IRQ,  8'h00, "rst_irq_out");
        expect_at(0, K_DATA, 8'h00, "rst_data_out");
        reset = 1'b1;
        tick(1);
        rd(2'd0, 8'h00, "rst_ctrl");
        rd(2'd1, 8'h00, "rst_mask");
        rd(2'd3, 8'h00, "rst_status");
        rd(2'd2, 8'h10, "rst_delay");
        expect_at(1, K_DATA, 8'h00, "unselected_read_zero");
        tick(1);
        rd(2'd2, 8'h10, "delay_reread");
        enable = 1'b1;
        addr   = BASE + AW'(4);
        expect_at(1, K_DATA, 8'h00, "out_of_range_read_zero");
        tick(1);
        enable = 1'b0;

        // Sleep with empty mask is ignored
        wr(2'd0, 8'h01);
        expect_at(0, K_CE, 8'h01, "mask0_sleep_ignored");
        expect_at(1, K_CE, 8'h01, "mask0_sleep_ignored_next");
        rd(2'd0, 8'h00, "mask0_ctrl_reads_0");

        // Delay 5, one-cycle pulse on irq_in[1]
        wr(2'd1, 8'h02);
        wr(2'd2, 8'h05);
        wr(2'd0, 8'h01);
        expect_at(0, K_CE, 8'h00, "sleep_entry_ce_low");
        rd(2'd0, 8'h01, "ctrl_reads_1_in_sleep");
        tick(1);
        irq_in = 4'h2;
        expect_at(0, K_IRQ, 8'h02, "irq_passthrough");
        tick(1);
        irq_in = 4'h0;
        for (int k = 0; k < 5; k++) expect_at(k, K_CE, 8'h00, "wake_delay_ce_low");
        expect_at(5, K_CE, 8'h01, "wake_delay_ce_rise");
        for (int k = 0; k < 6; k++) expect_at(k, K_IRQ, 8'h02, "pending_irq_held");
        expect_at(6, K_IRQ, 8'h00, "pending_irq_cleared");
        rd(2'd3, 8'h02, "status_after_wake_bit1");
        tick(7);

        // Delay 0 with interrupt already active: exactly one sleep cycle
        wr(2'd3, 8'h0F);
        wr(2'd2, 8'h00);
        wr(2'd1, 8'h01);
        irq_in = 4'h1;
        wr(2'd0, 8'h01);
        expect_at(0, K_CE, 8'h00, "d0_one_cycle_low");
        expect_at(1, K_CE, 8'h01, "d0_wake_immediate");
        expect_at(2, K_CE, 8'h01, "d0_stays_run");
        tick(1);
        rd(2'd3, 8'h01, "status_d0_bit0_only");
        irq_in = 4'h0;
        tick(2);

        // Unmasked interrupt does not wake; masked one does
        wr(2'd3, 8'h0F);
        wr(2'd2, 8'h02);
        wr(2'd0, 8'h01);
        expect_at(0, K_CE, 8'h00, "sleep_mask1_entry");
        irq_in = 4'h4;
        tick(1);
        irq_in = 4'h0;
        expect_at(0, K_CE, 8'h00, "unmasked_no_wake");
        expect_at(2, K_CE, 8'h00, "unmasked_no_wake_later");
        tick(3);
        irq_in = 4'h1;
        tick(1);
        irq_in = 4'h0;
        expect_at(0, K_CE, 8'h00, "masked_wake_d2_low0");
        expect_at(1, K_CE, 8'h00, "masked_wake_d2_low1");
        expect_at(2, K_CE, 8'h01, "masked_wake_d2_rise");
        rd(2'd3, 8'h01, "status_masked_only");
        tick(4);

        // Asynchronous reset in WAKE with counter at 3
        wr(2'd2, 8'h05);
        wr(2'd0, 8'h01);
        tick(1);
        irq_in = 4'h1;
        tick(1);
        irq_in = 4'h0;
        tick(2);
        reset = 1'b0;
        expect_at(0, K_CE,  8'h01, "async_reset_ce_high");
        expect_at(0, K_IRQ, 8'h00, "async_reset_pending_clear");
        @(negedge clk);
        #1;
        reset = 1'b1;
        tick(1);
        expect_at(0, K_CE, 8'h01, "reset_stays_run");
        rd(2'd3, 8'h00, "reset_status_zero");
        rd(2'd0, 8'h00, "reset_ctrl_zero");
        rd(2'd1, 8'h00, "reset_mask_zero");
        rd(2'd2, 8'h10, "reset_delay_default");

        // Wake on bit 3 in the same cycle as STATUS write-1-to-clear
        wr(2'd1, 8'h08);
        wr(2'd2, 8'h03);
        wr(2'd0, 8'h01);
        irq_in = 4'h8;
        wr(2'd3, 8'h0F);
        irq_in = 4'h0;
        rd(2'd3, 8'h08, "status_set_beats_clear");
        expect_at(3, K_CE, 8'h01, "race_wake_completes");
        tick(5);

        tick(3);
        while (q.size() > 0) begin
            n_checks++;
            $display("FAIL %s: never checked, expected 0x%0h at cycle %0d", q[0].name, q[0].val, q[0].cyc);
            void'(q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
